// File: rtl/ppu_host_writer.sv
// rtl/ppu_host_writer.sv - host write queue for PPU memories, drained during vblank
// Avalon-MM writes are queued and replayed into the PPU memory write ports one per cycle.
module ppu_host_writer #(
  parameter int FIFO_DEPTH  = 16,
  parameter bit VBLANK_ONLY = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [13:0]                   address,
  input  logic [31:0]                   write_data,
  output logic                          waitrequest,
  input  logic                          vblank,
  output logic                          we_tile_buffer,
  output logic                          we_tile_graphics,
  output logic                          we_sprite_graphics,
  output logic                          we_color_palettes,
  output logic                          we_OAM,
  output logic [8:0]                    addr_tile_buffer,
  output logic [10:0]                   addr_tile_graphics,
  output logic [10:0]                   addr_sprite_graphics,
  output logic [2:0]                    addr_color_palettes,
  output logic [7:0]                    addr_OAM,
  output logic [31:0]                   wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    bad_region_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + 11 + 32;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [4:0]      r_we;
  logic [10:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [7:0]      r_bad;

  logic            w_full;
  logic            w_req;
  logic            w_good_region;
  logic            w_push;
  logic            w_drop;
  logic            w_go;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic [2:0]      w_head_region;
  logic [10:0]     w_head_off;
  logic [31:0]     w_head_data;

  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_req         = chipselect & write & ~w_full;
  assign w_good_region = (address[13:11] <= 3'd4);
  assign w_push        = w_req & w_good_region;
  assign w_drop        = w_req & ~w_good_region;
  assign w_go          = (vblank | ~VBLANK_ONLY) & (r_count != '0);

  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_region = w_head[45:43];
  assign w_head_off    = w_head[42:32];
  assign w_head_data   = w_head[31:0];

  // The IDLE->DRAIN edge pops as well, so a lone entry strobes one cycle after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_DRAIN;
          w_pop       = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_go) begin
          w_pop = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {address, write_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_we     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_bad    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_we     <= 5'd1 << w_head_region;
        r_addr   <= w_head_off;
        r_wdata  <= w_head_data;
      end else begin
        r_we <= '0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop && r_bad != 8'hFF) begin
        r_bad <= r_bad + 8'd1;
      end
    end
  end

  assign waitrequest          = w_full;
  assign we_tile_buffer       = r_we[0];
  assign we_tile_graphics     = r_we[1];
  assign we_sprite_graphics   = r_we[2];
  assign we_color_palettes    = r_we[3];
  assign we_OAM               = r_we[4];
  assign addr_tile_buffer     = r_addr[8:0];
  assign addr_tile_graphics   = r_addr;
  assign addr_sprite_graphics = r_addr;
  assign addr_color_palettes  = r_addr[2:0];
  assign addr_OAM             = r_addr[7:0];
  assign wdata                = r_wdata;
  assign fifo_count           = r_count;
  assign bad_region_count     = r_bad;

endmodule

// File: tb/tb_ppu_host_writer.sv
// tb/tb_ppu_host_writer.sv - self-checking bench for ppu_host_writer
// A queue model predicts occupancy, strobes and drop counts; directed tests pin it with literals.
module tb_ppu_host_writer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [13:0] address;
  logic [31:0] write_data;
  logic        vblank;
  logic        waitrequest;
  logic        we_tile_buffer, we_tile_graphics, we_sprite_graphics, we_color_palettes, we_OAM;
  logic [8:0]  addr_tile_buffer;
  logic [10:0] addr_tile_graphics;
  logic [10:0] addr_sprite_graphics;
  logic [2:0]  addr_color_palettes;
  logic [7:0]  addr_OAM;
  logic [31:0] wdata;
  logic [4:0]  fifo_count;
  logic [7:0]  bad_region_count;
  logic [4:0]  w_we;

  always #5 clk = ~clk;

  ppu_host_writer #(.FIFO_DEPTH(DEPTH), .VBLANK_ONLY(1'b1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .chipselect           (chipselect),
    .write                (write),
    .address              (address),
    .write_data           (write_data),
    .waitrequest          (waitrequest),
    .vblank               (vblank),
    .we_tile_buffer       (we_tile_buffer),
    .we_tile_graphics     (we_tile_graphics),
    .we_sprite_graphics   (we_sprite_graphics),
    .we_color_palettes    (we_color_palettes),
    .we_OAM               (we_OAM),
    .addr_tile_buffer     (addr_tile_buffer),
    .addr_tile_graphics   (addr_tile_graphics),
    .addr_sprite_graphics (addr_sprite_graphics),
    .addr_color_palettes  (addr_color_palettes),
    .addr_OAM             (addr_OAM),
    .wdata                (wdata),
    .fifo_count           (fifo_count),
    .bad_region_count     (bad_region_count)
  );

  assign w_we = {we_OAM, we_color_palettes, we_sprite_graphics, we_tile_graphics, we_tile_buffer};

  int n_tests   = 0;
  int n_fail    = 0;
  int n_strobes = 0;
  bit cmp_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  r;
    logic [10:0] off;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_we    = '0;
  logic [10:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  int          m_bad   = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   full;
    bit   popping;
    if (reset) begin
      mq.delete();
      m_we  = '0;
      m_bad = 0;
    end else begin
      full    = (mq.size() == DEPTH);
      popping = vblank && (mq.size() > 0);
      m_we    = '0;
      if (popping) begin
        e       = mq.pop_front();
        m_we    = 5'd1 << e.r;
        m_addr  = e.off;
        m_wdata = e.d;
      end
      if (chipselect && write && !full) begin
        if (address[13:11] < 3'd5) begin
          e.r   = address[13:11];
          e.off = address[10:0];
          e.d   = write_data;
          mq.push_back(e);
        end else if (m_bad < 255) begin
          m_bad++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("count", fifo_count, mq.size());
      check("waitrequest", waitrequest, mq.size() == DEPTH);
      check("strobes", w_we, m_we);
      check("bad_count", bad_region_count, m_bad);
      if (m_we != 0) begin
        check("wdata", wdata, m_wdata);
        check("addr_tb", addr_tile_buffer, m_addr[8:0]);
        check("addr_tg", addr_tile_graphics, m_addr);
        check("addr_sg", addr_sprite_graphics, m_addr);
        check("addr_pal", addr_color_palettes, m_addr[2:0]);
        check("addr_oam", addr_OAM, m_addr[7:0]);
      end
      if (w_we != 0) n_strobes++;
    end
  end

  task automatic host_write(input logic [2:0] r, input logic [10:0] off, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = {r, off};
    write_data = d;
    while (waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", waitrequest, 1'b0);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int s0;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; write_data = '0; vblank = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", fifo_count, 0);
    check("rst_we", w_we, 0);
    check("rst_wdata", wdata, 0);
    check("rst_addr", addr_tile_graphics, 0);
    check("rst_bad", bad_region_count, 0);
    check("rst_wait", waitrequest, 0);
    cmp_en = 1'b1;
    reset  = 1'b0;

    // reset discards queued entries
    for (int i = 0; i < 3; i++) host_write(3'd0, 11'(i), 32'h100 + i);
    @(negedge clk);
    check("t1_count3", fifo_count, 3);
    reset = 1'b1;
    @(negedge clk);
    check("t1_count0", fifo_count, 0);
    reset  = 1'b0;
    vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_no_strobe", w_we, 0);
    end
    vblank = 1'b0;

    // single write replayed when vblank rises
    host_write(3'd0, 11'd5, 32'hDEADBEEF);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    check("t2_we_tb", we_tile_buffer, 1);
    check("t2_addr", addr_tile_buffer, 5);
    check("t2_wdata", wdata, 32'hDEADBEEF);
    vblank = 1'b0;

    // full FIFO holds the 17th write until the drain frees a slot
    for (int i = 0; i < 16; i++) host_write(3'd0, 11'(i), 32'h300 + i);
    @(negedge clk);
    check("t3_full_wait", waitrequest, 1);
    check("t3_full_count", fifo_count, 16);
    fork
      host_write(3'd1, 11'd16, 32'h300 + 16);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t3_held", waitrequest, 1);
        end
        vblank = 1'b1;
        for (int i = 0; i < 17; i++) begin
          @(negedge clk);
          check("t3_no_gap", (w_we != 0), 1);
          check("t3_order", wdata, 32'h300 + i);
        end
      end
    join
    @(negedge clk);
    check("t3_empty", fifo_count, 0);
    vblank = 1'b0;

    // bad regions are dropped and counted with saturation
    host_write(3'd6, 11'd0, 32'h0);
    @(negedge clk);
    check("t4_bad1", bad_region_count, 1);
    check("t4_not_queued", fifo_count, 0);
    for (int i = 1; i < 300; i++) host_write(3'(5 + i % 3), 11'(i), 32'(i));
    @(negedge clk);
    check("t4_bad_sat", bad_region_count, 255);

    // palette write with vblank already high: strobe exactly one cycle after acceptance
    vblank = 1'b1;
    host_write(3'd3, 11'd2, 32'hAA112233);
    @(negedge clk);
    check("t5_no_bypass", w_we, 0);
    @(negedge clk);
    check("t5_we_pal", we_color_palettes, 1);
    check("t5_addr", addr_color_palettes, 2);
    check("t5_wdata", wdata[23:0], 24'h112233);
    vblank = 1'b0;
    @(negedge clk);
    check("t5_one_cycle", w_we, 0);

    // short vblank window drains part of the queue
    for (int i = 0; i < 8; i++) host_write(3'd4, 11'(i), 32'h600 + i);
    s0 = n_strobes;
    @(negedge clk);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    check("t6_count5", fifo_count, 5);
    check("t6_third", wdata, 32'h602);
    repeat (3) @(negedge clk);
    #1;
    check("t6_strobes3", n_strobes - s0, 3);
    @(negedge clk);
    vblank = 1'b1;
    repeat (5) @(negedge clk);
    vblank = 1'b0;
    check("t6_last", wdata, 32'h607);
    repeat (2) @(negedge clk);
    #1;
    check("t6_strobes8", n_strobes - s0, 8);
    check("t6_empty", fifo_count, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
